// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing with a
// memory-wait timeout, an illegal-instruction trap and a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned MAX_WAIT   = 15,
    parameter int unsigned ECALL_HALT = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       inst_i,
    input  logic [2:0]       funct3_i,
    input  logic             mem_ready_i,
    input  logic             branch_taken_i,
    output logic             mem_req_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             branch_o,
    output logic             memRead_o,
    output logic             memWrite_o,
    output logic             ALUSrc_o,
    output logic             regWrite_o,
    output logic             unsignedFlag_o,
    output logic [2:0]       memToReg_o,
    output logic [1:0]       ALUOp_o,
    output logic [2:0]       memOffset_o,
    output logic [1:0]       PC_mux_o,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic             illegal_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 2);

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StHalt    = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsR, ClsI, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsNop
    } cls_e;

    state_e             state_q, state_d;
    cls_e               cls_q, cls_d, dec_cls;
    logic [2:0]         f3_q, f3_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               dec_bad, dec_halt, wait_hit;

    logic       mem_req, ir_write, pc_write, branch, mem_read, mem_write;
    logic       alu_src, reg_write, unsigned_flag;
    logic [2:0] mem_to_reg, mem_offset;
    logic [1:0] alu_op, pc_mux;

    // The access that is still waiting would be the MAX_WAIT-th wait cycle.
    assign wait_hit = (32'(wait_q) + 32'd1) >= MAX_WAIT;

    always_comb begin
        dec_cls  = ClsNop;
        dec_bad  = 1'b0;
        dec_halt = 1'b0;
        case (inst_i)
            7'b0110011: dec_cls = ClsR;
            7'b0010011: dec_cls = ClsI;
            7'b0000011: begin
                dec_cls = ClsLoad;
                dec_bad = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
            end
            7'b0100011: begin
                dec_cls = ClsStore;
                dec_bad = funct3_i >= 3'b011;
            end
            7'b1100011: dec_cls = ClsBranch;
            7'b1101111: dec_cls = ClsJal;
            7'b1100111: dec_cls = ClsJalr;
            7'b0110111: dec_cls = ClsLui;
            7'b0010111: dec_cls = ClsAuipc;
            7'b0001111: dec_cls = ClsNop;
            7'b1110011: begin
                dec_cls  = ClsNop;
                dec_halt = ECALL_HALT != 0;
            end
            default:    dec_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        f3_d      = f3_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            StFetch, StMem: begin
                if (mem_ready_i) begin
                    if (state_q == StFetch) begin
                        state_d = StDecode;
                    end else if (cls_q == ClsLoad) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                    end
                end else if (wait_hit) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                cls_d = dec_cls;
                f3_d  = funct3_i;
                if (dec_bad) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else if (dec_halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                case (cls_q)
                    ClsBranch, ClsNop: state_d = StFetch;
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StWb;
                endcase
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase
        if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
            wait_d = '0;
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        unsigned_flag = 1'b0;
        mem_to_reg    = 3'b000;
        alu_op        = 2'b00;
        mem_offset    = 3'b000;
        pc_mux        = 2'b00;
        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                mem_read   = 1'b1;
                mem_offset = 3'b100;
                ir_write   = mem_ready_i;
            end
            StExecute: begin
                case (cls_q)
                    ClsR: alu_op = 2'b10;
                    ClsI: begin
                        alu_op  = 2'b01;
                        alu_src = 1'b1;
                    end
                    ClsLoad, ClsStore, ClsJalr: alu_src = 1'b1;
                    ClsBranch: begin
                        branch   = 1'b1;
                        alu_op   = 2'b11;
                        pc_write = 1'b1;
                        pc_mux   = branch_taken_i ? 2'b11 : 2'b00;
                    end
                    ClsNop:  pc_write = 1'b1;
                    default: ;
                endcase
            end
            StMem: begin
                mem_req   = 1'b1;
                mem_read  = cls_q == ClsLoad;
                mem_write = cls_q == ClsStore;
                pc_write  = (cls_q == ClsStore) && mem_ready_i;
                case (f3_q)
                    3'b000:  mem_offset = 3'b001;
                    3'b001:  mem_offset = 3'b010;
                    3'b010:  mem_offset = 3'b100;
                    3'b100: begin
                        mem_offset    = 3'b001;
                        unsigned_flag = 1'b1;
                    end
                    3'b101: begin
                        mem_offset    = 3'b010;
                        unsigned_flag = 1'b1;
                    end
                    default: mem_offset = 3'b000;
                endcase
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                case (cls_q)
                    ClsLui:         mem_to_reg = 3'b011;
                    ClsAuipc:       mem_to_reg = 3'b100;
                    ClsJal, ClsJalr: mem_to_reg = 3'b010;
                    ClsLoad:        mem_to_reg = 3'b001;
                    default:        mem_to_reg = 3'b000;
                endcase
                if (cls_q == ClsJal) begin
                    pc_mux = 2'b01;
                end else if (cls_q == ClsJalr) begin
                    pc_mux = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign instret_d = instret_q + CNT_W'(pc_write);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StFetch;
            cls_q     <= ClsNop;
            f3_q      <= 3'b000;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            f3_q      <= f3_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            instret_q <= instret_d;
        end
    end

    // Reset gates the decoded controls so the FETCH request cannot leak out during reset.
    assign mem_req_o      = mem_req & rst_ni;
    assign ir_write_o     = ir_write & rst_ni;
    assign pc_write_o     = pc_write & rst_ni;
    assign branch_o       = branch & rst_ni;
    assign memRead_o      = mem_read & rst_ni;
    assign memWrite_o     = mem_write & rst_ni;
    assign ALUSrc_o       = alu_src & rst_ni;
    assign regWrite_o     = reg_write & rst_ni;
    assign unsignedFlag_o = unsigned_flag & rst_ni;
    assign memToReg_o     = mem_to_reg & {3{rst_ni}};
    assign ALUOp_o        = alu_op & {2{rst_ni}};
    assign memOffset_o    = mem_offset & {3{rst_ni}};
    assign PC_mux_o       = pc_mux & {2{rst_ni}};
    assign state_o        = state_q;
    assign halted_o       = (state_q == StHalt) & rst_ni;
    assign illegal_o      = illegal_q;
    assign timeout_o      = timeout_q;
    assign instret_o      = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words are queued with
// the stimulus and compared against the DUT in the middle of each clock cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, irw, pcw, rw, mr, mw, br, asrc, uns;
        logic [2:0] m2r;
        logic [1:0] aop;
        logic [2:0] off;
        logic [1:0] pcm;
    } ctl_t;

    typedef struct packed {
        logic rdy;
        logic tk;
        ctl_t c;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0, rst_n2 = 1'b0;
    logic [6:0] inst = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic mem_ready = 1'b0, branch_taken = 1'b0;

    logic mem_req, ir_write, pc_write, branch, memRead, memWrite, ALUSrc, regWrite, uns;
    logic [2:0] memToReg, memOffset, state;
    logic [1:0] ALUOp, PC_mux;
    logic halted, illegal, timeout;
    logic [31:0] instret;

    logic mem_req2, ir_write2, pc_write2, branch2, memRead2, memWrite2, ALUSrc2, regWrite2, uns2;
    logic [2:0] memToReg2, memOffset2, state2;
    logic [1:0] ALUOp2, PC_mux2;
    logic halted2, illegal2, timeout2;
    logic [31:0] instret2;

    ctl_t obs, obs2;
    step_t q[$];
    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    multicycle_control u_dut (
        .clk_i(clk), .rst_ni(rst_n), .inst_i(inst), .funct3_i(funct3),
        .mem_ready_i(mem_ready), .branch_taken_i(branch_taken),
        .mem_req_o(mem_req), .ir_write_o(ir_write), .pc_write_o(pc_write), .branch_o(branch),
        .memRead_o(memRead), .memWrite_o(memWrite), .ALUSrc_o(ALUSrc), .regWrite_o(regWrite),
        .unsignedFlag_o(uns), .memToReg_o(memToReg), .ALUOp_o(ALUOp), .memOffset_o(memOffset),
        .PC_mux_o(PC_mux), .state_o(state), .halted_o(halted), .illegal_o(illegal),
        .timeout_o(timeout), .instret_o(instret)
    );

    multicycle_control #(.ECALL_HALT(0)) u_nop (
        .clk_i(clk), .rst_ni(rst_n2), .inst_i(inst), .funct3_i(funct3),
        .mem_ready_i(mem_ready), .branch_taken_i(branch_taken),
        .mem_req_o(mem_req2), .ir_write_o(ir_write2), .pc_write_o(pc_write2),
        .branch_o(branch2), .memRead_o(memRead2), .memWrite_o(memWrite2),
        .ALUSrc_o(ALUSrc2), .regWrite_o(regWrite2), .unsignedFlag_o(uns2),
        .memToReg_o(memToReg2), .ALUOp_o(ALUOp2), .memOffset_o(memOffset2),
        .PC_mux_o(PC_mux2), .state_o(state2), .halted_o(halted2), .illegal_o(illegal2),
        .timeout_o(timeout2), .instret_o(instret2)
    );

    always_comb begin
        obs = {state, mem_req, ir_write, pc_write, regWrite, memRead, memWrite, branch, ALUSrc,
               uns, memToReg, ALUOp, memOffset, PC_mux};
        obs2 = {state2, mem_req2, ir_write2, pc_write2, regWrite2, memRead2, memWrite2, branch2,
                ALUSrc2, uns2, memToReg2, ALUOp2, memOffset2, PC_mux2};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic ctl_t c_fetch(input logic rdy);
        ctl_t c = '0;
        c.mreq = 1'b1;
        c.mr   = 1'b1;
        c.off  = 3'b100;
        c.irw  = rdy;
        return c;
    endfunction

    function automatic ctl_t c_dec();
        ctl_t c = '0;
        c.st = 3'd1;
        return c;
    endfunction

    function automatic ctl_t c_exec(input logic [1:0] aop, input logic asrc, input logic br,
                                    input logic pcw, input logic [1:0] pcm);
        ctl_t c = '0;
        c.st   = 3'd2;
        c.aop  = aop;
        c.asrc = asrc;
        c.br   = br;
        c.pcw  = pcw;
        c.pcm  = pcm;
        return c;
    endfunction

    function automatic ctl_t c_mem(input logic mr, input logic mw, input logic [2:0] off,
                                   input logic u, input logic pcw);
        ctl_t c = '0;
        c.st   = 3'd3;
        c.mreq = 1'b1;
        c.mr   = mr;
        c.mw   = mw;
        c.off  = off;
        c.uns  = u;
        c.pcw  = pcw;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic [2:0] m2r, input logic [1:0] pcm);
        ctl_t c = '0;
        c.st  = 3'd4;
        c.rw  = 1'b1;
        c.pcw = 1'b1;
        c.m2r = m2r;
        c.pcm = pcm;
        return c;
    endfunction

    function automatic ctl_t c_halt();
        ctl_t c = '0;
        c.st = 3'd5;
        return c;
    endfunction

    task automatic push(input logic rdy, input logic tk, input ctl_t c);
        step_t s;
        s.rdy = rdy;
        s.tk  = tk;
        s.c   = c;
        q.push_back(s);
    endtask

    task automatic start(input logic [6:0] op, input logic [2:0] f3);
        inst   = op;
        funct3 = f3;
        push(1'b1, 1'b0, c_fetch(1'b1));
        push(1'b0, 1'b0, c_dec());
    endtask

    // Entered at a falling edge; drives each step, samples 1 ns later, moves to next falling edge.
    task automatic run(input string tag, input bit sel);
        step_t s;
        int n = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            mem_ready    = s.rdy;
            branch_taken = s.tk;
            #1;
            check($sformatf("%s[%0d]", tag, n), sel ? obs2 : obs, s.c);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_flags", {halted, illegal, timeout}, 3'b000);
        check("rst_instret", instret, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ctl", obs, '0);
        check("rst_instret", instret, 0);
        check("rst_halted", halted, 0);
        rst_n = 1'b1;

        start(7'b0110011, 3'b000);
        push(1'b0, 1'b0, c_exec(2'b10, 1'b0, 1'b0, 1'b0, 2'b00));
        push(1'b0, 1'b0, c_wb(3'b000, 2'b00));
        run("rtype", 0);
        check("rtype_ret", instret, ++exp_ret);

        start(7'b0010011, 3'b000);
        push(1'b0, 1'b0, c_exec(2'b01, 1'b1, 1'b0, 1'b0, 2'b00));
        push(1'b0, 1'b0, c_wb(3'b000, 2'b00));
        run("itype", 0);
        check("itype_ret", instret, ++exp_ret);

        start(7'b0000011, 3'b100);
        push(1'b0, 1'b0, c_exec(2'b00, 1'b1, 1'b0, 1'b0, 2'b00));
        push(1'b0, 1'b0, c_mem(1'b1, 1'b0, 3'b001, 1'b1, 1'b0));
        push(1'b0, 1'b0, c_mem(1'b1, 1'b0, 3'b001, 1'b1, 1'b0));
        push(1'b1, 1'b0, c_mem(1'b1, 1'b0, 3'b001, 1'b1, 1'b0));
        push(1'b0, 1'b0, c_wb(3'b001, 2'b00));
        run("lbu", 0);
        check("lbu_ret", instret, ++exp_ret);

        start(7'b1100011, 3'b000);
        push(1'b0, 1'b1, c_exec(2'b11, 1'b0, 1'b1, 1'b1, 2'b11));
        run("br_tk", 0);
        check("br_tk_ret", instret, ++exp_ret);

        start(7'b1100011, 3'b001);
        push(1'b0, 1'b0, c_exec(2'b11, 1'b0, 1'b1, 1'b1, 2'b00));
        run("br_nt", 0);
        check("br_nt_ret", instret, ++exp_ret);

        start(7'b1101111, 3'b000);
        push(1'b0, 1'b0, c_exec(2'b00, 1'b0, 1'b0, 1'b0, 2'b00));
        push(1'b0, 1'b0, c_wb(3'b010, 2'b01));
        run("jal", 0);

        start(7'b1100111, 3'b000);
        push(1'b0, 1'b0, c_exec(2'b00, 1'b1, 1'b0, 1'b0, 2'b00));
        push(1'b0, 1'b0, c_wb(3'b010, 2'b10));
        run("jalr", 0);

        start(7'b0110111, 3'b000);
        push(1'b0, 1'b0, c_exec(2'b00, 1'b0, 1'b0, 1'b0, 2'b00));
        push(1'b0, 1'b0, c_wb(3'b011, 2'b00));
        run("lui", 0);

        start(7'b0010111, 3'b000);
        push(1'b0, 1'b0, c_exec(2'b00, 1'b0, 1'b0, 1'b0, 2'b00));
        push(1'b0, 1'b0, c_wb(3'b100, 2'b00));
        run("auipc", 0);
        exp_ret += 4;
        check("jumps_ret", instret, exp_ret);

        inst = 7'b0001111;
        push(1'b0, 1'b0, c_fetch(1'b0));
        push(1'b1, 1'b0, c_fetch(1'b1));
        push(1'b0, 1'b0, c_dec());
        push(1'b0, 1'b0, c_exec(2'b00, 1'b0, 1'b0, 1'b1, 2'b00));
        run("fence", 0);
        check("fence_ret", instret, ++exp_ret);

        start(7'b0100011, 3'b001);
        push(1'b0, 1'b0, c_exec(2'b00, 1'b1, 1'b0, 1'b0, 2'b00));
        push(1'b1, 1'b0, c_mem(1'b0, 1'b1, 3'b010, 1'b0, 1'b1));
        run("sh", 0);
        check("sh_ret", instret, ++exp_ret);

        start(7'b0100011, 3'b010);
        push(1'b0, 1'b0, c_exec(2'b00, 1'b1, 1'b0, 1'b0, 2'b00));
        push(1'b0, 1'b0, c_mem(1'b0, 1'b1, 3'b100, 1'b0, 1'b0));
        run("sw", 0);
        #1;
        check("sw_wait_mw", memWrite, 1);
        rst_n = 1'b0;
        #1;
        check("sw_rst_ctl", obs, '0);
        check("sw_rst_ret", instret, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = 0;

        start(7'b1110011, 3'b000);
        push(1'b0, 1'b0, c_halt());
        push(1'b1, 1'b0, c_halt());
        run("ecall", 0);
        check("ecall_hlt", {halted, illegal, timeout}, 3'b100);
        check("ecall_ret", instret, exp_ret);
        do_reset();

        start(7'b1111111, 3'b000);
        push(1'b0, 1'b0, c_halt());
        run("bad_op", 0);
        check("bad_op_flags", {halted, illegal, timeout}, 3'b110);
        do_reset();

        start(7'b0000011, 3'b110);
        push(1'b0, 1'b0, c_halt());
        run("bad_ld", 0);
        check("bad_ld_flags", {halted, illegal, timeout}, 3'b110);
        do_reset();

        start(7'b0100011, 3'b011);
        push(1'b0, 1'b0, c_halt());
        run("bad_st", 0);
        check("bad_st_flags", {halted, illegal, timeout}, 3'b110);
        do_reset();

        for (int i = 0; i < 15; i++) push(1'b0, 1'b0, c_fetch(1'b0));
        push(1'b0, 1'b0, c_halt());
        push(1'b1, 1'b0, c_halt());
        run("tmo", 0);
        check("tmo_flags", {halted, illegal, timeout, mem_req}, 4'b1010);
        check("tmo_ret", instret, 0);

        rst_n2 = 1'b1;
        start(7'b1110011, 3'b000);
        push(1'b0, 1'b0, c_exec(2'b00, 1'b0, 1'b0, 1'b1, 2'b00));
        push(1'b0, 1'b0, c_fetch(1'b0));
        run("ecall_nop", 1);
        check("ecall_nop_ret", instret2, 1);
        check("ecall_nop_hlt", halted2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, giving the memory wait cycles allowed per access before a timeout halt.
REQ-002 SHALL have parameter ECALL_HALT, default 1: 1 = ECALL/EBREAK halts, 0 = ECALL/EBREAK retires as NOP.
REQ-003 SHALL have parameter CNT_W, default 32, giving the retired-instruction counter width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 inst  in  7  opcode of the instruction register; valid from DECODE onward.
REQ-007 funct3  in  3  funct3 of the instruction register.
REQ-008 mem_ready  in  1  memory acknowledge for the current mem_req.
REQ-009 branch_taken  in  1  branch comparator result, sampled in EXECUTE.
REQ-010 mem_req  out  1  memory access request.
REQ-011 ir_write, pc_write  out  1 each  instruction-register load and PC load strobes.
REQ-012 branch, memRead, memWrite, ALUSrc, regWrite, unsignedFlag  out  1 each  datapath controls.
REQ-013 memToReg  out  3  writeback source: 000 ALU, 001 mem, 010 PC+4, 011 imm, 100 PC+imm.
REQ-014 ALUOp  out  2  ALU class: 00 add, 01 I-type, 10 R-type, 11 branch.
REQ-015 memOffset  out  3  access size: 001 byte, 010 half, 100 word.
REQ-016 PC_mux  out  2  PC source: 00 PC+4, 01 PC+imm, 10 rs1+imm, 11 branch target.
REQ-017 state  out  3  current state; halted  out  1; illegal  out  1; timeout  out  1.
REQ-018 instret  out  CNT_W  retired-instruction count.

Function
REQ-019 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5; encodings 6–7 SHALL go to HALT on the next edge.
REQ-020 FETCH behaviour:
- assert mem_req=1 and memRead=1; memOffset=100.
- on mem_ready=1: assert ir_write=1 in the same cycle and go to DECODE.
REQ-021 Wait counter:
- clears on entry to FETCH and to MEM, and increments on each cycle with mem_ready=0.
- when it reaches MAX_WAIT with mem_ready still 0: go to HALT and set timeout=1.
REQ-022 DECODE opcode class:
- latch the class and funct3 into internal registers, then go to EXECUTE.
- illegal opcode, load funct3 in {011,110,111}, or store funct3 >= 011: go to HALT and set illegal=1.
REQ-023 FENCE (0001111) SHALL retire as NOP: pc_write=1, PC_mux=00, then FETCH. ECALL/EBREAK (1110011) follows ECALL_HALT: HALT if 1, NOP as FENCE if 0.
REQ-024 EXECUTE outputs: ALUOp and ALUSrc per class.
- R: ALUOp=10, ALUSrc=0.
- I, load, store, JALR: ALUSrc=1; I uses ALUOp=01, others ALUOp=00.
- branch: branch=1, ALUOp=11.
REQ-025 EXECUTE exit:
- branch: pc_write=1; PC_mux=11 if branch_taken=1, else 00; go to FETCH.
- load/store: go to MEM.
- all other classes: go to WB.
REQ-026 MEM behaviour:
- assert mem_req=1 with memRead (load) or memWrite (store).
- memOffset and unsignedFlag from funct3: 000→001/0, 001→010/0, 010→100/0, 100→001/1, 101→010/1.
- on mem_ready=1: load goes to WB; store asserts pc_write=1, PC_mux=00 and goes to FETCH.
REQ-027 WB behaviour:
- assert regWrite=1 and pc_write=1.
- memToReg: LUI 011, AUIPC 100, JAL/JALR 010, load 001, R/I 000.
- PC_mux: JAL 01, JALR 10, else 00.
- then go to FETCH.
REQ-028 Any control output not stated for the current state SHALL be 0; outputs SHALL be decoded from state and latched class only, with no dependence on inst after DECODE.
REQ-029 instret SHALL increment by 1 in each cycle with pc_write=1 and wrap modulo 2^CNT_W.
REQ-030 Cycle counts with zero-wait memory: branch/FENCE 3, R/I/LUI/AUIPC/JAL/JALR 4, store 4, load 5; each memory wait cycle adds 1.
REQ-031 HALT behaviour:
- halted=1; all strobes, mem_req, regWrite and memWrite are 0.
- illegal/timeout remain held.
- exit only by reset.

Reset
REQ-032 While rst=0, state SHALL be FETCH, and all outputs, instret, wait counter, illegal, timeout and halted SHALL be 0; mem_req SHALL be gated to 0.
REQ-033 Reset asserted mid-access SHALL abort the access immediately with no pc_write or regWrite; the first FETCH request SHALL occur in the first cycle after rst rises.

Verification
REQ-034 Scenarios a bench SHALL cover:
- R-type 0110011, mem_ready=1 always → states 0,1,2,4; regWrite=1 only in WB; instret 0→1 after 4 cycles.
- Load funct3=100, MEM ready after 2 wait cycles → 7 cycles total; MEM shows memOffset=001, unsignedFlag=1; WB shows memToReg=001.
- Branch with branch_taken=1 → pc_write=1 and PC_mux=11 in cycle 3; regWrite never 1.
- mem_ready stuck 0 in FETCH, MAX_WAIT=15 → HALT after 15 wait cycles, timeout=1, mem_req=0 thereafter.
- Opcode 1110011 with ECALL_HALT=1 → HALT, halted=1, instret unchanged; with ECALL_HALT=0 → NOP, instret +1.
- rst pulsed low during MEM of a store → memWrite drops at once, state=0, instret=0.
